// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute over a shared
// memory with a req/ready handshake, wait timeout, and retired-instruction counter.
module mips_multicycle_ctrl #(
    parameter int WAIT_TIMEOUT = 16,
    parameter int CNT_W        = 32,
    parameter bit SUPPORT_JAL  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             branch,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             ori_ctrl,
    output logic             illegal,
    output logic             mem_fault,
    output logic [3:0]       state_out,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11,
        ORIEX  = 4'd12,
        JAL    = 4'd13,
        ORIWB  = 4'd14,
        HALT   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // The counter only needs to hold 0..WAIT_TIMEOUT-1: the cycle on which it
    // would reach WAIT_TIMEOUT is the cycle the FSM leaves for HALT.
    localparam int WCNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST =
        (WAIT_TIMEOUT > 0) ? WCNT_W'(WAIT_TIMEOUT - 1) : '0;

    state_t             state_reg, state_next;
    logic [WCNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic               illegal_reg, mem_fault_reg;
    logic [CNT_W-1:0]   retired_cnt_reg;
    logic               illegal_set, fault_set, retire, timeout_now;

    assign timeout_now = (WAIT_TIMEOUT > 0) && (wait_cnt_reg == WAIT_LAST);

    always_comb begin
        state_next    = state_reg;
        illegal_set   = 1'b0;
        fault_set     = 1'b0;
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        branch        = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 2'b00;
        mem_to_reg    = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_src        = 2'b00;
        ori_ctrl      = 1'b0;
        retire        = 1'b0;
        wait_cnt_next = '0;

        if (reset) begin
            case (state_reg)
                FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    if (mem_ready) begin
                        state_next = DECODE;
                    end else if (timeout_now) begin
                        state_next = HALT;
                        fault_set  = 1'b1;
                    end
                end
                DECODE: begin
                    alu_src_b = 2'b11;
                    case (opcode)
                        OP_LW, OP_SW: state_next = MEMADR;
                        OP_RTYPE:     state_next = EXEC;
                        OP_BEQ:       state_next = BRANCH;
                        OP_ADDI:      state_next = ADDIEX;
                        OP_ORI:       state_next = ORIEX;
                        OP_J:         state_next = JUMP;
                        OP_JAL: begin
                            if (SUPPORT_JAL) begin
                                state_next = JAL;
                            end else begin
                                state_next  = HALT;
                                illegal_set = 1'b1;
                            end
                        end
                        default: begin
                            state_next  = HALT;
                            illegal_set = 1'b1;
                        end
                    endcase
                end
                MEMADR: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = 2'b10;
                    state_next = (opcode == OP_LW) ? MEMRD : MEMWR;
                end
                MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    if (mem_ready) begin
                        state_next = MEMWB;
                    end else if (timeout_now) begin
                        state_next = HALT;
                        fault_set  = 1'b1;
                    end
                end
                MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'b01;
                    state_next = FETCH;
                end
                MEMWR: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    if (mem_ready) begin
                        state_next = FETCH;
                    end else if (timeout_now) begin
                        state_next = HALT;
                        fault_set  = 1'b1;
                    end
                end
                EXEC: begin
                    alu_src_a  = 1'b1;
                    alu_op     = 2'b10;
                    state_next = ALUWB;
                end
                ALUWB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'b01;
                    state_next = FETCH;
                end
                BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_op     = 2'b01;
                    pc_src     = 2'b01;
                    branch     = 1'b1;
                    state_next = FETCH;
                end
                ADDIEX: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = 2'b10;
                    state_next = ADDIWB;
                end
                ADDIWB: begin
                    reg_write  = 1'b1;
                    state_next = FETCH;
                end
                ORIEX: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = 2'b10;
                    alu_op     = 2'b11;
                    ori_ctrl   = 1'b1;
                    state_next = ORIWB;
                end
                ORIWB: begin
                    reg_write  = 1'b1;
                    ori_ctrl   = 1'b1;
                    state_next = FETCH;
                end
                JUMP: begin
                    pc_write   = 1'b1;
                    pc_src     = 2'b10;
                    state_next = FETCH;
                end
                JAL: begin
                    // PC was already advanced to PC+4 in FETCH, so it is the link value.
                    pc_write   = 1'b1;
                    pc_src     = 2'b10;
                    reg_write  = 1'b1;
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b10;
                    state_next = FETCH;
                end
                default: state_next = HALT;
            endcase

            // Every path back to FETCH is an instruction completing.
            retire = (state_reg != FETCH) && (state_next == FETCH);

            if ((WAIT_TIMEOUT > 0) && mem_req && !mem_ready && (state_next == state_reg)) begin
                wait_cnt_next = wait_cnt_reg + WCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= FETCH;
            wait_cnt_reg    <= '0;
            illegal_reg     <= 1'b0;
            mem_fault_reg   <= 1'b0;
            retired_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            illegal_reg   <= illegal_reg | illegal_set;
            mem_fault_reg <= mem_fault_reg | fault_set;
            if (retire) begin
                retired_cnt_reg <= retired_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign illegal     = illegal_reg;
    assign mem_fault   = mem_fault_reg;
    assign state_out   = state_reg;
    assign retired_cnt = retired_cnt_reg;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: the driver pushes per-cycle expected
// state/controls, a negedge monitor pops and compares against the selected DUT.
module tb_mips_multicycle_ctrl;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] ORI  = 6'b001101;
    localparam logic [5:0] J    = 6'b000010;
    localparam logic [5:0] JALO = 6'b000011;
    localparam logic [5:0] BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;

    always #5 clk = ~clk;

    // DUT A: timeout 4, jal supported
    logic       mem_req_a, mem_write_a, iord_a, ir_write_a, pc_write_a, branch_a, reg_write_a;
    logic [1:0] reg_dst_a, mem_to_reg_a, alu_src_b_a, alu_op_a, pc_src_a;
    logic       alu_src_a_a, ori_ctrl_a, illegal_a, mem_fault_a;
    logic [3:0] state_out_a;
    logic [7:0] retired_cnt_a;

    // DUT B: timeout disabled, jal illegal, 3-bit counter to exercise wrap
    logic       mem_req_b, mem_write_b, iord_b, ir_write_b, pc_write_b, branch_b, reg_write_b;
    logic [1:0] reg_dst_b, mem_to_reg_b, alu_src_b_b, alu_op_b, pc_src_b;
    logic       alu_src_a_b, ori_ctrl_b, illegal_b, mem_fault_b;
    logic [3:0] state_out_b;
    logic [2:0] retired_cnt_b;

    mips_multicycle_ctrl #(.WAIT_TIMEOUT(4), .CNT_W(8), .SUPPORT_JAL(1'b1)) dut_a (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req_a), .mem_write(mem_write_a), .iord(iord_a), .ir_write(ir_write_a),
        .pc_write(pc_write_a), .branch(branch_a), .reg_write(reg_write_a), .reg_dst(reg_dst_a),
        .mem_to_reg(mem_to_reg_a), .alu_src_a(alu_src_a_a), .alu_src_b(alu_src_b_a),
        .alu_op(alu_op_a), .pc_src(pc_src_a), .ori_ctrl(ori_ctrl_a), .illegal(illegal_a),
        .mem_fault(mem_fault_a), .state_out(state_out_a), .retired_cnt(retired_cnt_a)
    );

    mips_multicycle_ctrl #(.WAIT_TIMEOUT(0), .CNT_W(3), .SUPPORT_JAL(1'b0)) dut_b (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req_b), .mem_write(mem_write_b), .iord(iord_b), .ir_write(ir_write_b),
        .pc_write(pc_write_b), .branch(branch_b), .reg_write(reg_write_b), .reg_dst(reg_dst_b),
        .mem_to_reg(mem_to_reg_b), .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b),
        .alu_op(alu_op_b), .pc_src(pc_src_b), .ori_ctrl(ori_ctrl_b), .illegal(illegal_b),
        .mem_fault(mem_fault_b), .state_out(state_out_b), .retired_cnt(retired_cnt_b)
    );

    logic [18:0] ctl_a, ctl_b;
    assign ctl_a = {mem_req_a, mem_write_a, iord_a, ir_write_a, pc_write_a, branch_a, reg_write_a,
                    reg_dst_a, mem_to_reg_a, alu_src_a_a, alu_src_b_a, alu_op_a, pc_src_a, ori_ctrl_a};
    assign ctl_b = {mem_req_b, mem_write_b, iord_b, ir_write_b, pc_write_b, branch_b, reg_write_b,
                    reg_dst_b, mem_to_reg_b, alu_src_a_b, alu_src_b_b, alu_op_b, pc_src_b, ori_ctrl_b};

    typedef struct packed {
        logic        sel;
        logic [3:0]  st;
        logic [18:0] ctl;
        logic        ill;
        logic        flt;
        logic [31:0] cnt;
        logic [31:0] id;
    } exp_t;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;
    int   step = 0;
    int   ecnt = 0;

    function automatic logic [18:0] cw(int mreq, int mwr, int io, int irw, int pcw, int br, int rw,
                                       int rd, int m2r, int a, int b, int op, int pcs, int ori);
        return {1'(mreq), 1'(mwr), 1'(io), 1'(irw), 1'(pcw), 1'(br), 1'(rw),
                2'(rd), 2'(m2r), 1'(a), 2'(b), 2'(op), 2'(pcs), 1'(ori)};
    endfunction

    // Control table written out per state from the datapath's point of view.
    function automatic logic [18:0] exp_ctl(int st, int rdy);
        case (st)
            0:  return cw(1, 0, 0, rdy, rdy, 0, 0, 0, 0, 0, 1, 0, 0, 0);
            1:  return cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0);
            2:  return cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
            3:  return cw(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            4:  return cw(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
            5:  return cw(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            6:  return cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0);
            7:  return cw(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
            8:  return cw(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 1, 0);
            9:  return cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
            10: return cw(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
            11: return cw(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0);
            12: return cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 0, 1);
            13: return cw(0, 0, 0, 0, 1, 0, 1, 2, 2, 0, 0, 0, 2, 0);
            14: return cw(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
            default: return '0;
        endcase
    endfunction

    // One clock cycle: apply inputs just after the edge and queue what the monitor must see.
    task automatic cyc(input int sel, input int rst, input logic [5:0] op, input int rdy,
                       input int st, input int ill, input int flt, input int cnt);
        exp_t e;
        reset     = 1'(rst);
        opcode    = op;
        mem_ready = 1'(rdy);
        e.sel = 1'(sel);
        e.st  = 4'(st);
        e.ctl = (rst != 0) ? exp_ctl(st, rdy) : '0;
        e.ill = 1'(ill);
        e.flt = 1'(flt);
        e.cnt = 32'((sel != 0) ? (cnt % 8) : (cnt % 256));
        e.id  = 32'(step);
        step++;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Zero-wait instruction: FETCH then the listed states (one nibble each), then retire.
    task automatic run_path(input int sel, input logic [5:0] op, input logic [15:0] path, input int n);
        cyc(sel, 1, op, 1, 0, 0, 0, ecnt);
        for (int i = 0; i < n; i++) begin
            cyc(sel, 1, op, 1, int'(path[4*i +: 4]), 0, 0, ecnt);
        end
        ecnt++;
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [3:0]  st_act;
        logic [18:0] ctl_act;
        logic        ill_act, flt_act;
        logic [31:0] cnt_act;
        while (sb.size() > 0) begin
            e       = sb.pop_front();
            st_act  = e.sel ? state_out_b : state_out_a;
            ctl_act = e.sel ? ctl_b : ctl_a;
            ill_act = e.sel ? illegal_b : illegal_a;
            flt_act = e.sel ? mem_fault_b : mem_fault_a;
            cnt_act = e.sel ? {29'd0, retired_cnt_b} : {24'd0, retired_cnt_a};
            compared++;
            if (st_act !== e.st || ctl_act !== e.ctl || ill_act !== e.ill ||
                flt_act !== e.flt || cnt_act !== e.cnt) begin
                mismatched++;
                $display("FAIL step %0d dut_%s: got st=%0d ctl=%05h ill=%0b flt=%0b cnt=%0d, want st=%0d ctl=%05h ill=%0b flt=%0b cnt=%0d",
                         e.id, e.sel ? "b" : "a", st_act, ctl_act, ill_act, flt_act, cnt_act,
                         e.st, e.ctl, e.ill, e.flt, e.cnt);
            end else begin
                $display("step %0d dut_%s ok: st=%0d ctl=%05h ill=%0b flt=%0b cnt=%0d",
                         e.id, e.sel ? "b" : "a", st_act, ctl_act, ill_act, flt_act, cnt_act);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not reach its end, step=%0d required completion", step);
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        // Reset held: FSM in FETCH but all controls forced low
        cyc(0, 0, RT, 0, 0, 0, 0, 0);
        cyc(0, 0, RT, 1, 0, 0, 0, 0);

        // lw, zero wait: 0,1,2,3,4,0
        run_path(0, LW, 16'h4321, 4);

        // lw stalled in MEMRD, reset mid-access, release
        cyc(0, 1, LW, 1, 0, 0, 0, ecnt);
        cyc(0, 1, LW, 1, 1, 0, 0, ecnt);
        cyc(0, 1, LW, 1, 2, 0, 0, ecnt);
        cyc(0, 1, LW, 0, 3, 0, 0, ecnt);
        cyc(0, 1, LW, 0, 3, 0, 0, ecnt);
        cyc(0, 0, LW, 0, 0, 0, 0, 0);
        ecnt = 0;
        cyc(0, 1, LW, 0, 0, 0, 0, 0);

        // sw with three wait cycles in MEMWR; ready on the fourth (limit cycle)
        cyc(0, 1, SW, 1, 0, 0, 0, ecnt);
        cyc(0, 1, SW, 1, 1, 0, 0, ecnt);
        cyc(0, 1, SW, 1, 2, 0, 0, ecnt);
        cyc(0, 1, SW, 0, 5, 0, 0, ecnt);
        cyc(0, 1, SW, 0, 5, 0, 0, ecnt);
        cyc(0, 1, SW, 0, 5, 0, 0, ecnt);
        cyc(0, 1, SW, 1, 5, 0, 0, ecnt);
        ecnt++;

        run_path(0, RT,   16'h0761, 3);
        run_path(0, BEQ,  16'h0081, 2);
        run_path(0, ADDI, 16'h0A91, 3);
        run_path(0, ORI,  16'h0EC1, 3);
        run_path(0, J,    16'h00B1, 2);
        run_path(0, JALO, 16'h00D1, 2);

        // Fetch timeout: four wait cycles then HALT with mem_fault
        for (int i = 0; i < 4; i++) cyc(0, 1, RT, 0, 0, 0, 0, ecnt);
        for (int i = 0; i < 3; i++) cyc(0, 1, LW, 1, 15, 0, 1, ecnt);
        cyc(0, 0, RT, 0, 0, 0, 0, 0);
        ecnt = 0;

        // Ready on the fourth wait cycle wins over the timeout
        for (int i = 0; i < 3; i++) cyc(0, 1, J, 0, 0, 0, 0, ecnt);
        cyc(0, 1, J, 1, 0, 0, 0, ecnt);
        cyc(0, 1, J, 1, 1, 0, 0, ecnt);
        cyc(0, 1, J, 1, 11, 0, 0, ecnt);
        ecnt++;

        // Illegal opcode halts and stays halted until reset
        cyc(0, 1, BAD, 1, 0, 0, 0, ecnt);
        cyc(0, 1, BAD, 1, 1, 0, 0, ecnt);
        for (int i = 0; i < 10; i++) cyc(0, 1, (i % 2 == 0) ? LW : RT, i % 2, 15, 1, 0, ecnt);
        cyc(0, 0, RT, 0, 0, 0, 0, 0);
        ecnt = 0;

        // DUT B: jal is illegal when unsupported
        cyc(1, 1, JALO, 1, 0, 0, 0, ecnt);
        cyc(1, 1, JALO, 1, 1, 0, 0, ecnt);
        cyc(1, 1, JALO, 1, 15, 1, 0, ecnt);
        cyc(1, 1, JALO, 0, 15, 1, 0, ecnt);
        cyc(1, 0, RT, 0, 0, 0, 0, 0);

        // DUT B: no timeout, FETCH waits indefinitely
        for (int i = 0; i < 20; i++) cyc(1, 1, J, 0, 0, 0, 0, 0);

        // DUT B: eight retirements wrap the 3-bit counter back to 0
        ecnt = 0;
        for (int k = 0; k < 8; k++) run_path(1, J, 16'h00B1, 2);
        cyc(1, 1, J, 0, 0, 0, 0, ecnt);

        @(negedge clk);
        #1;
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the next-generation multi-cycle MIPS core. It replaces the single-cycle combinational decoder with a shared-memory, state-sequenced controller.
- Handles variable-latency memory through a req/ready handshake, with a parametrised wait timeout and a retired-instruction counter.
- Drives the existing datapath muxes (PC source, ALU sources, register destination, result select). The ALU function decoder stays external and consumes alu_op.

Parameters:
- WAIT_TIMEOUT, 16: max cycles mem_req may wait for mem_ready before fault; 0 disables timeout.
- CNT_W, 32: width of retired-instruction counter.
- SUPPORT_JAL, 1: 1 decodes jal (opcode 000011); 0 treats it as illegal.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- opcode  input  6  instruction[31:26] from instruction register
- mem_ready  input  1  memory completes current access this cycle
- mem_req  output  1  memory access request (held until mem_ready)
- mem_write  output  1  write strobe, valid with mem_req
- iord  output  1  0 = address from PC, 1 = address from ALU out register
- ir_write  output  1  load instruction register
- pc_write  output  1  unconditional PC load
- branch  output  1  conditional PC load; datapath loads PC when branch & zero
- reg_write  output  1  register file write enable
- reg_dst  output  2  00 rt, 01 rd, 10 r31
- mem_to_reg  output  2  00 ALU out, 01 memory data, 10 PC
- alu_src_a  output  1  0 PC, 1 register A
- alu_src_b  output  2  00 register B, 01 constant 4, 10 extended imm, 11 extended imm << 2
- alu_op  output  2  00 add, 01 sub, 10 funct-decoded, 11 or
- pc_src  output  2  00 ALU result, 01 ALU out register, 10 jump target
- ori_ctrl  output  1  zero-extend immediate
- illegal  output  1  sticky; unknown opcode decoded
- mem_fault  output  1  sticky; memory wait timeout
- state_out  output  4  current state encoding
- retired_cnt  output  CNT_W  instructions completed since reset

Behaviour:
- Reset (reset=0, async): state = FETCH (0), all control outputs 0, illegal = mem_fault = 0, retired_cnt = 0, wait counter = 0. The effect is immediate, including mid-access; any in-flight access is abandoned.
- All control outputs are a Moore decode of state, except ir_write/pc_write in FETCH, which are gated by mem_ready.
- State encoding and outputs (outputs not listed are 0):
  - FETCH=0: mem_req=1, iord=0, a=0, b=01, op=00, pc_src=00. ir_write = pc_write = mem_ready. Goes to DECODE when mem_ready is high, else stays.
  - DECODE=1: a=0, b=11, op=00. Next state by opcode:
    - 100011/101011 -> MEMADR=2
    - 000000 -> EXEC=6
    - 000100 -> BRANCH=8
    - 001000 -> ADDIEX=9
    - 001101 -> ORIEX=12
    - 000010 -> JUMP=11
    - 000011 -> JAL=13 (only if SUPPORT_JAL)
    - else -> HALT=15 with illegal=1.
  - MEMADR=2: a=1, b=10, op=00. Goes to MEMRD=3 if opcode is lw, else MEMWR=5.
  - MEMRD=3: mem_req=1, iord=1. Goes to MEMWB=4 on mem_ready.
  - MEMWB=4: reg_write=1, reg_dst=00, mem_to_reg=01. Goes to FETCH; retire.
  - MEMWR=5: mem_req=1, mem_write=1, iord=1. Goes to FETCH on mem_ready; retire in that cycle.
  - EXEC=6: a=1, b=00, op=10. Goes to ALUWB=7.
  - ALUWB=7: reg_write=1, reg_dst=01, mem_to_reg=00. Goes to FETCH; retire.
  - BRANCH=8: a=1, b=00, op=01, pc_src=01, branch=1. Goes to FETCH; retire.
  - ADDIEX=9: a=1, b=10, op=00. Goes to ADDIWB=10.
  - ADDIWB=10: reg_write=1, reg_dst=00, mem_to_reg=00. Goes to FETCH; retire.
  - ORIEX=12: a=1, b=10, op=11, ori_ctrl=1. Goes to ORIWB=14.
  - ORIWB=14: as ADDIWB, plus ori_ctrl=1. Goes to FETCH; retire.
  - JUMP=11: pc_write=1, pc_src=10. Goes to FETCH; retire.
  - JAL=13: pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10 (PC already holds PC+4). Goes to FETCH; retire.
  - HALT=15: all enables 0, no mem_req. Stays until reset.
- Wait counter:
  - Clears on entry to any mem_req state and on mem_ready.
  - Increments each cycle mem_req=1 and mem_ready=0.
  - If WAIT_TIMEOUT>0 and the counter reaches WAIT_TIMEOUT with mem_ready=0, the next state is HALT and mem_fault=1.
  - If mem_ready arrives in the same cycle the limit is reached, mem_ready wins.
- retired_cnt increments by 1 on the clock edge leaving a retire state. It wraps modulo 2^CNT_W and does not saturate.
- Latencies with zero-wait memory:
  - lw 5 cycles; sw 4
  - R-type/addi/ori 4
  - beq/j/jal 3
- illegal and mem_fault are never both set: the first fault halts the FSM.

Test Plan:
- Reset mid-MEMRD with mem_ready=0, release -> state_out=0, mem_req=1, iord=0, retired_cnt=0, all write enables 0.
- lw, mem_ready tied 1 -> state sequence 0,1,2,3,4,0. MEMWB shows reg_write=1, mem_to_reg=01. retired_cnt increments 0->1.
- sw, mem_ready delayed 3 cycles in MEMWR -> mem_req/mem_write held 4 cycles. No reg_write at any point. retire fires only on the ready cycle.
- Opcode 111111 -> DECODE->HALT, illegal=1, state_out=15. FSM stays halted for 10 cycles until reset.
- WAIT_TIMEOUT=4, mem_ready=0 in FETCH -> HALT after 4 wait cycles, mem_fault=1. Repeat with mem_ready=1 on the 4th wait cycle -> DECODE, no fault.
- jal (SUPPORT_JAL=1) -> 0,1,13,0 with reg_dst=10, mem_to_reg=10, pc_src=10 in JAL. With SUPPORT_JAL=0 -> illegal=1.
